// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared constants, FSM states and register decode for the AXI4-lite UART TX slave
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;

  localparam int CTRL_IE_BIT      = 0;
  localparam int CTRL_FLUSH_BIT   = 1;
  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 8;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_AW, W_WAIT_W, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;
  typedef enum logic [1:0] {SEL_TXDATA, SEL_STATUS, SEL_CTRL, SEL_NONE} reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic hit, input logic [3:0] nib);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (hit) begin
      case (nib)
        REG_TXDATA: sel = SEL_TXDATA;
        REG_STATUS: sel = SEL_STATUS;
        REG_CTRL:   sel = SEL_CTRL;
        default:    sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/axi4lite_uart_tx_slave_if.sv
// rtl/axi4lite_uart_tx_slave_if.sv - AXI4-lite bus bundle with master and slave views
interface axi4lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4lite_uart_tx_slave_fifo.sv
// rtl/axi4lite_uart_tx_slave_fifo.sv - synchronous FIFO with push/pop/flush and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // full is judged before any same-cycle pop, so a full FIFO never accepts
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/axi4lite_uart_tx_slave.sv
// rtl/axi4lite_uart_tx_slave.sv - AXI4-lite slave buffering console bytes into a TX FIFO
module axi4lite_uart_tx_slave
  import axi4lite_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'ha000_03f8)
) (
  input  logic       aclk,
  input  logic       areset,
  axi4lite_if.slave  s_axi,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       irq
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int STRB_W = DATA_W / 8;

  w_state_e            wstate_q;
  logic                awready_q, wready_q, bvalid_q;
  logic [1:0]          bresp_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  r_state_e            rstate_q;
  logic                arready_q, rvalid_q;
  logic [1:0]          rresp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ie_q;

  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  logic                aw_hs, w_hs, ar_hs, wr_fire;
  logic [ADDR_W-1:0]   wr_addr, wr_off, rd_off;
  logic [DATA_W-1:0]   wr_data, rd_val;
  logic [STRB_W-1:0]   wr_strb;
  reg_sel_e            wr_sel, rd_sel;
  logic                fifo_push, fifo_flush, ctrl_we;
  logic [1:0]          wr_resp, rd_resp;
  logic                unused_bits;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign aw_hs = s_axi.awvalid & awready_q;
  assign w_hs  = s_axi.wvalid & wready_q;
  assign ar_hs = s_axi.arvalid & arready_q;

  // the write takes effect in the cycle its second half arrives
  assign wr_fire = ((wstate_q == W_IDLE) && aw_hs && w_hs) ||
                   ((wstate_q == W_WAIT_AW) && aw_hs) ||
                   ((wstate_q == W_WAIT_W) && w_hs);
  assign wr_addr = (wstate_q == W_WAIT_W)  ? awaddr_q : s_axi.awaddr;
  assign wr_data = (wstate_q == W_WAIT_AW) ? wdata_q  : s_axi.wdata;
  assign wr_strb = (wstate_q == W_WAIT_AW) ? wstrb_q  : s_axi.wstrb;

  // the base is not 16-byte aligned, so decode the offset rather than raw address bits
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_off = s_axi.araddr - BASE_ADDR;
  assign wr_sel = decode_reg(wr_off[ADDR_W-1:4] == '0, wr_off[3:0]);
  assign rd_sel = decode_reg(rd_off[ADDR_W-1:4] == '0, rd_off[3:0]);

  always_comb begin
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    ctrl_we    = 1'b0;
    wr_resp    = RESP_OKAY;
    if (wr_fire) begin
      case (wr_sel)
        SEL_TXDATA: begin
          if (wr_strb[0]) begin
            if (fifo_full) wr_resp = RESP_SLVERR;
            else           fifo_push = 1'b1;
          end
        end
        SEL_CTRL: begin
          ctrl_we    = wr_strb[0];
          fifo_flush = wr_strb[0] & wr_data[CTRL_FLUSH_BIT];
        end
        SEL_NONE: wr_resp = RESP_DECERR;
        default:  wr_resp = RESP_OKAY;
      endcase
    end
  end

  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      SEL_STATUS: begin
        rd_val[STATUS_EMPTY_BIT]         = fifo_empty;
        rd_val[STATUS_FULL_BIT]          = fifo_full;
        rd_val[STATUS_COUNT_LSB +: 8]    = 8'(fifo_count);
      end
      SEL_CTRL: rd_val[CTRL_IE_BIT] = ie_q;
      SEL_NONE: rd_resp = RESP_DECERR;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ie_q      <= 1'b0;
    end else begin
      if (ctrl_we) ie_q <= wr_data[CTRL_IE_BIT];
      if (wr_fire) bresp_q <= wr_resp;
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            wstate_q  <= W_RESP;
          end else if (aw_hs) begin
            awready_q <= 1'b0;
            awaddr_q  <= s_axi.awaddr;
            wstate_q  <= W_WAIT_W;
          end else if (w_hs) begin
            wready_q  <= 1'b0;
            wdata_q   <= s_axi.wdata;
            wstrb_q   <= s_axi.wstrb;
            wstate_q  <= W_WAIT_AW;
          end
        end
        W_WAIT_AW: begin
          if (aw_hs) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b1;
            wstate_q  <= W_RESP;
          end
        end
        W_WAIT_W: begin
          if (w_hs) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            wstate_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_val;
            rresp_q   <= rd_resp;
            rstate_q  <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axi.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rdata_q   <= '0;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (fifo_push),
    .data_i  (wr_data[7:0]),
    .pop_i   (tx_ready),
    .flush_i (fifo_flush),
    .data_o  (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tx_valid = ~fifo_empty;
  assign irq      = fifo_empty & ie_q;

  assign unused_bits = ^{wr_data[DATA_W-1:8], wr_strb[STRB_W-1:1]};
endmodule

// File: doc/axi4lite_uart_tx_slave.md
Name: axi4lite_uart_tx_slave

Overview:
- Parametrised AXI4-lite slave that fronts a character-output device (console/UART TX) for the CPU's MMIO path.
- Full AXI4-lite compliance:
  - independent AW/W acceptance
  - registered B/R responses
  - back-pressure honoured on every channel
- Written bytes are buffered in a TX FIFO and drained over a valid/ready byte stream to the console sink.
- Status and control registers are readable over the read channel.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (32 or 64); wstrb width = DATA_W/8.
- FIFO_DEPTH, 16, TX FIFO entries (power of two, >=2).
- BASE_ADDR, 32'ha000_03f8, base of the 3-register window; registers sit at BASE_ADDR + 0/4/8.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- awvalid / awready  in / out  1  write address handshake.
- awaddr  in  ADDR_W  write address.
- wvalid / wready  in / out  1  write data handshake.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte strobes.
- bvalid / bready  out / in  1  write response handshake.
- bresp  out  2  write response code.
- arvalid / arready  in / out  1  read address handshake.
- araddr  in  ADDR_W  read address.
- rvalid / rready  out / in  1  read data handshake.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response code.
- tx_valid / tx_ready  out / in  1  byte stream handshake to the sink.
- tx_data  out  8  byte presented to the sink.
- irq  out  1  level interrupt: FIFO empty AND CTRL.ie=1.

Behaviour:
- Reset (areset=1 at a rising edge):
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, tx_valid=0, irq=0.
  - FIFO emptied; CTRL=0.
  - Reset mid-transaction discards any latched AW/W and any pending B/R; no response is ever issued for it.
- Register map (offset from BASE_ADDR):
  - 0x0 TXDATA (W): byte = wdata[7:0]; pushed only if wstrb[0]=1.
  - 0x4 STATUS (R): bit0 empty, bit1 full, bits[15:8] occupancy count; all other bits read 0.
  - 0x8 CTRL (RW): bit0 ie, bit1 flush (self-clearing, reads 0).
  - Writes to STATUS are ignored but still answered OKAY.
- Decode uses addr[3:0] only after a base match on the upper bits; any other address is a decode error.
- Write channel:
  - AW and W are each accepted on their own valid&ready; the accepted channel drops its ready and holds until the other arrives.
  - The effect is applied in the cycle both are held; bvalid rises the next cycle.
  - awready/wready stay low while bvalid=1, reassert the cycle after the bready&bvalid handshake.
  - AW and W arriving in the same cycle is allowed: B comes 1 cycle later.
  - One outstanding write maximum.
- Write responses:
  - OKAY (2'b00) normally.
  - SLVERR (2'b10) for TXDATA with the FIFO full; the byte is dropped and the FIFO is unchanged.
  - DECERR (2'b11) for an unmapped address.
- Read channel:
  - AR is accepted when arready=1; arready drops and rvalid+rdata+rresp register the next cycle.
  - rdata/rresp are held stable until rready; arready returns 1 the cycle after the handshake.
  - Reading TXDATA returns 0 with OKAY; unmapped address returns 0 with DECERR.
- Read and write paths are independent. A STATUS read in the same cycle as a TXDATA push returns the pre-push value.
- FIFO:
  - Push on an accepted TXDATA write when not full; pop on tx_valid&tx_ready.
  - Simultaneous push+pop when full is still refused: full is evaluated before the pop.
  - Simultaneous push+pop when non-full keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.
  - tx_valid = !empty; tx_data = head entry, combinational from FIFO storage.
- Flush: a CTRL write with bit1=1 empties the FIFO in the same cycle the write is applied; it overrides a concurrent pop.

Decomposition:
- Package axi4lite_pkg holds:
  - resp constants RESP_OKAY/RESP_SLVERR/RESP_DECERR;
  - register offsets REG_TXDATA/REG_STATUS/REG_CTRL;
  - CTRL bit indices;
  - write-FSM state enum {W_IDLE, W_WAIT_AW, W_WAIT_W, W_RESP};
  - read-FSM state enum {R_IDLE, R_RESP}.
- One sub-module: sync_fifo (params WIDTH=8, DEPTH) with push/pop/flush, full/empty/count. It is reusable for a future RX path.

Test Plan:
- AW and W in the same cycle to BASE+0, wdata=0x41, wstrb=0xF, tx_ready=0 -> bvalid 1 cycle later with bresp=00; STATUS read gives 0x0000_0100 (count 1, not empty).
- W two cycles before AW, then bready held low 3 cycles -> awready/wready stay 0 and bvalid/bresp stay stable until bready=1; a single push occurs.
- 17 TXDATA writes with tx_ready=0, FIFO_DEPTH=16 -> writes 1-16 answered 00, write 17 answered 10; STATUS=0x0000_1002; tx_ready=1 then drains bytes in write order.
- Read of BASE+0xC and write to 0x8000_0000 -> rresp=11 with rdata=0, and bresp=11; FIFO and CTRL unchanged.
- CTRL write 0x1, FIFO drains to empty -> irq=1; a CTRL write 0x3 with 5 bytes queued -> FIFO empty next cycle, CTRL reads back 0x1.
- areset pulsed while AW is latched and rvalid is pending -> the next cycle shows bvalid=0, rvalid=0, all readies=1, FIFO empty, irq=0.
